fpu_result_buffer: RTL and testbench

Downstream stage of the custom FPU. It captures each completed FPU result (32-bit word in the team format: [31] sign, [30:21] exponent, [20:0] mantissa) together with its 4-bit status code. Results go into a first-word-fall-through FIFO, so a slower consumer (display or UART) can drain them with a valid/pop handshake. The block also keeps saturating per-status event counters for debug and verification.

---
 rtl/fpu_result_buffer.sv | 122 ++++++++++++
 tb/tb_fpu_result_buffer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_result_buffer.sv
// Result buffer behind the FPU: a first-word-fall-through FIFO of {status, data}
// entries, plus saturating per-status debug event counters.
module fpu_result_buffer #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clock_100KHz,
    input  logic                     reset,
    input  logic                     result_valid_in,
    input  logic [31:0]              data_in,
    input  logic [3:0]               status_in,
    input  logic                     pop_in,
    input  logic                     clear_cnt_in,
    output logic [31:0]              data_out,
    output logic [3:0]               status_out,
    output logic                     out_valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         cnt_exact,
    output logic [CNT_W-1:0]         cnt_overflow,
    output logic [CNT_W-1:0]         cnt_underflow,
    output logic [CNT_W-1:0]         cnt_inexact,
    output logic [CNT_W-1:0]         cnt_dropped,
    output logic [CNT_W-1:0]         cnt_illegal
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    localparam logic [3:0] ST_EXACT     = 4'b0001;
    localparam logic [3:0] ST_OVERFLOW  = 4'b0011;
    localparam logic [3:0] ST_UNDERFLOW = 4'b0111;
    localparam logic [3:0] ST_INEXACT   = 4'b1111;

    logic [35:0]      mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level_q;
    logic [35:0]      head;
    logic             legal;
    logic             push_ok;
    logic             pop_ok;
    logic [5:0]       inc;
    logic [CNT_W-1:0] cnt_q [6];

    // Handshake: the head entry is offered whenever out_valid is high and is
    // consumed on a rising edge where pop_in is also high; pop_in alone is ignored.
    assign out_valid = (level_q != '0);
    assign full      = (level_q == FULL_LVL);
    assign level     = level_q;

    assign legal   = (status_in == ST_EXACT) || (status_in == ST_OVERFLOW) ||
                     (status_in == ST_UNDERFLOW) || (status_in == ST_INEXACT);
    assign pop_ok  = pop_in && out_valid;
    assign push_ok = result_valid_in && legal && (!full || pop_ok);

    assign head       = mem[rd_ptr];
    assign data_out   = out_valid ? head[31:0]  : 32'h0;
    assign status_out = out_valid ? head[35:32] : 4'h0;

    always_ff @(posedge clock_100KHz) begin
        if (push_ok) begin
            mem[wr_ptr] <= {status_in, data_in};
        end
    end

    always_ff @(posedge clock_100KHz or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Exactly one event per strobe: stored by status, dropped when full, or illegal.
    always_comb begin
        inc    = '0;
        inc[0] = push_ok && (status_in == ST_EXACT);
        inc[1] = push_ok && (status_in == ST_OVERFLOW);
        inc[2] = push_ok && (status_in == ST_UNDERFLOW);
        inc[3] = push_ok && (status_in == ST_INEXACT);
        inc[4] = result_valid_in && legal && !push_ok;
        inc[5] = result_valid_in && !legal;
    end

    always_ff @(posedge clock_100KHz or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 6; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (clear_cnt_in) begin
                    cnt_q[i] <= '0;
                end else if (inc[i] && (cnt_q[i] != '1)) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign cnt_exact     = cnt_q[0];
    assign cnt_overflow  = cnt_q[1];
    assign cnt_underflow = cnt_q[2];
    assign cnt_inexact   = cnt_q[3];
    assign cnt_dropped   = cnt_q[4];
    assign cnt_illegal   = cnt_q[5];

endmodule

// File: tb/tb_fpu_result_buffer.sv
// Bench for fpu_result_buffer: vector table, hand-written corner sequences and
// random traffic, all checked against a queue-based model of the FIFO and counters.
`timescale 1ns/1ps
module tb_fpu_result_buffer;

    localparam int DEPTH = 8;
    localparam int CNT_W = 16;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic        clk;
    logic        rst_n;
    logic        result_valid_in;
    logic [31:0] data_in;
    logic [3:0]  status_in;
    logic        pop_in;
    logic        clear_cnt_in;
    logic [31:0] data_out;
    logic [3:0]  status_out;
    logic        out_valid;
    logic        full;
    logic [3:0]  level;
    logic [CNT_W-1:0] cnt_exact, cnt_overflow, cnt_underflow, cnt_inexact;
    logic [CNT_W-1:0] cnt_dropped, cnt_illegal;

    fpu_result_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock_100KHz    (clk),
        .reset           (rst_n),
        .result_valid_in (result_valid_in),
        .data_in         (data_in),
        .status_in       (status_in),
        .pop_in          (pop_in),
        .clear_cnt_in    (clear_cnt_in),
        .data_out        (data_out),
        .status_out      (status_out),
        .out_valid       (out_valid),
        .full            (full),
        .level           (level),
        .cnt_exact       (cnt_exact),
        .cnt_overflow    (cnt_overflow),
        .cnt_underflow   (cnt_underflow),
        .cnt_inexact     (cnt_inexact),
        .cnt_dropped     (cnt_dropped),
        .cnt_illegal     (cnt_illegal)
    );

    // clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard state: expected FIFO contents and event counts
    logic [35:0] exp_q[$];
    int          exp_cnt[6];
    int          checks;
    int          errors;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic [3:0]  s;
        logic        p;
        logic [3:0]  lvl;
        logic        ov;
        logic [31:0] hd;
        logic [3:0]  hs;
    } vec_t;

    vec_t        tbl[8];
    logic [3:0]  legal_codes[4];
    logic [31:0] drain_exp[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [3:0] s);
        return (s == 4'b0001) || (s == 4'b0011) || (s == 4'b0111) || (s == 4'b1111);
    endfunction

    function automatic int code_idx(input logic [3:0] s);
        case (s)
            4'b0001: return 0;
            4'b0011: return 1;
            4'b0111: return 2;
            default: return 3;
        endcase
    endfunction

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < 6; i++) exp_cnt[i] = 0;
    endtask

    task automatic bump(input int idx);
        if (exp_cnt[idx] < MAXC) exp_cnt[idx]++;
    endtask

    task automatic compare_all();
        logic        ov;
        logic [35:0] hd;
        ov = (exp_q.size() != 0);
        hd = ov ? exp_q[0] : 36'h0;
        check("level", 64'(level), 64'(exp_q.size()));
        check("full", 64'(full), 64'(exp_q.size() == DEPTH));
        check("out_valid", 64'(out_valid), 64'(ov));
        check("data_out", 64'(data_out), 64'(hd[31:0]));
        check("status_out", 64'(status_out), 64'(hd[35:32]));
        check("cnt_exact", 64'(cnt_exact), 64'(exp_cnt[0]));
        check("cnt_overflow", 64'(cnt_overflow), 64'(exp_cnt[1]));
        check("cnt_underflow", 64'(cnt_underflow), 64'(exp_cnt[2]));
        check("cnt_inexact", 64'(cnt_inexact), 64'(exp_cnt[3]));
        check("cnt_dropped", 64'(cnt_dropped), 64'(exp_cnt[4]));
        check("cnt_illegal", 64'(cnt_illegal), 64'(exp_cnt[5]));
    endtask

    // driver: present one cycle of inputs, advance the model, compare after the edge
    task automatic step(input logic v, input logic [31:0] d, input logic [3:0] s,
                        input logic p, input logic c);
        bit pop_acc;
        result_valid_in = v;
        data_in         = d;
        status_in       = s;
        pop_in          = p;
        clear_cnt_in    = c;
        pop_acc = p && (exp_q.size() != 0);
        if (pop_acc) void'(exp_q.pop_front());
        if (v) begin
            if (!is_legal(s)) bump(5);
            else if (exp_q.size() < DEPTH) begin
                exp_q.push_back({s, d});
                bump(code_idx(s));
            end else bump(4);
        end
        if (c) for (int i = 0; i < 6; i++) exp_cnt[i] = 0;
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        result_valid_in = 1'b0;
        pop_in          = 1'b0;
        clear_cnt_in    = 1'b0;
        rst_n           = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        result_valid_in = 1'b0;
        data_in = 32'h0;
        status_in = 4'h0;
        pop_in = 1'b0;
        clear_cnt_in = 1'b0;
        rst_n = 1'b1;
        legal_codes[0] = 4'b0001;
        legal_codes[1] = 4'b0011;
        legal_codes[2] = 4'b0111;
        legal_codes[3] = 4'b1111;

        // reset then idle
        #2;
        do_reset();
        repeat (3) idle();
        check("idle_out_valid", 64'(out_valid), 64'd0);
        check("idle_level", 64'(level), 64'd0);
        check("idle_data", 64'(data_out), 64'd0);

        // vector table: single result, pop, illegal codes, pop while empty
        tbl[0] = '{1'b1, 32'h4020_0000, 4'b0001, 1'b0, 4'd1, 1'b1, 32'h4020_0000, 4'b0001};
        tbl[1] = '{1'b0, 32'h0,         4'b0000, 1'b0, 4'd1, 1'b1, 32'h4020_0000, 4'b0001};
        tbl[2] = '{1'b0, 32'h0,         4'b0000, 1'b1, 4'd0, 1'b0, 32'h0,         4'b0000};
        tbl[3] = '{1'b1, 32'h0000_0000, 4'b0000, 1'b0, 4'd0, 1'b0, 32'h0,         4'b0000};
        tbl[4] = '{1'b1, 32'h0000_1234, 4'b0101, 1'b0, 4'd0, 1'b0, 32'h0,         4'b0000};
        tbl[5] = '{1'b1, 32'h1111_0000, 4'b0011, 1'b1, 4'd1, 1'b1, 32'h1111_0000, 4'b0011};
        tbl[6] = '{1'b1, 32'h0000_2222, 4'b0111, 1'b1, 4'd1, 1'b1, 32'h0000_2222, 4'b0111};
        tbl[7] = '{1'b0, 32'h0,         4'b0000, 1'b1, 4'd0, 1'b0, 32'h0,         4'b0000};
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].s, tbl[i].p, 1'b0);
            check("tbl_level", 64'(level), 64'(tbl[i].lvl));
            check("tbl_valid", 64'(out_valid), 64'(tbl[i].ov));
            check("tbl_data", 64'(data_out), 64'(tbl[i].hd));
            check("tbl_status", 64'(status_out), 64'(tbl[i].hs));
        end
        check("tbl_cnt_exact", 64'(cnt_exact), 64'd1);
        check("tbl_cnt_illegal", 64'(cnt_illegal), 64'd2);
        check("tbl_cnt_underflow", 64'(cnt_underflow), 64'd1);

        // fill, overflow drop, then push+pop while full
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 32'(i), 4'b0011, 1'b0, 1'b0);
        step(1'b1, 32'hDEAD_BEEF, 4'b0011, 1'b0, 1'b0);
        check("fill_full", 64'(full), 64'd1);
        check("fill_level", 64'(level), 64'd8);
        check("fill_cnt_overflow", 64'(cnt_overflow), 64'd8);
        check("fill_cnt_dropped", 64'(cnt_dropped), 64'd1);
        step(1'b1, 32'h0000_00AA, 4'b1111, 1'b1, 1'b0);
        check("pp_level", 64'(level), 64'd8);
        check("pp_cnt_dropped", 64'(cnt_dropped), 64'd1);
        check("pp_cnt_inexact", 64'(cnt_inexact), 64'd1);
        for (int i = 0; i < 7; i++) drain_exp[i] = 32'(i + 1);
        drain_exp[7] = 32'h0000_00AA;
        for (int i = 0; i < 8; i++) begin
            check("drain_order", 64'(data_out), 64'(drain_exp[i]));
            step(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
        end
        check("drain_empty", 64'(out_valid), 64'd0);

        // illegal codes, then pointer wrap with push/pop pairs
        do_reset();
        step(1'b1, 32'h5555_5555, 4'b0000, 1'b0, 1'b0);
        step(1'b1, 32'h6666_6666, 4'b0101, 1'b0, 1'b0);
        check("illegal_cnt", 64'(cnt_illegal), 64'd2);
        check("illegal_level", 64'(level), 64'd0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 32'h0100_0000 + 32'(i), 4'b0111, 1'b0, 1'b0);
            check("wrap_head", 64'(data_out), 64'(32'h0100_0000 + 32'(i)));
            step(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
        end
        check("wrap_cnt_underflow", 64'(cnt_underflow), 64'd20);

        // counter clear coincident with a strobe, then asynchronous reset
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 32'hC000_0000 + 32'(i), 4'b0001, 1'b0, 1'b0);
        step(1'b1, 32'hC000_0003, 4'b0001, 1'b0, 1'b1);
        check("clr_cnt_exact", 64'(cnt_exact), 64'd0);
        check("clr_level", 64'(level), 64'd4);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_level", 64'(level), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle();

        // random traffic: push-heavy, then pop-heavy
        for (int i = 0; i < 600; i++) begin
            logic [3:0] s;
            logic       v, p, c;
            s = ($urandom_range(0, 4) == 0) ? 4'($urandom) : legal_codes[$urandom_range(0, 3)];
            if (i < 300) begin
                v = ($urandom_range(0, 9) < 8);
                p = ($urandom_range(0, 3) == 0);
            end else begin
                v = ($urandom_range(0, 9) < 4);
                p = ($urandom_range(0, 9) < 7);
            end
            c = ($urandom_range(0, 59) == 0);
            step(v, $urandom, s, p, c);
        end

        // counter saturation
        do_reset();
        for (int i = 0; i < MAXC + 4; i++) step(1'b1, 32'h0, 4'b1010, 1'b0, 1'b0);
        check("sat_cnt_illegal", 64'(cnt_illegal), 64'(MAXC));
        step(1'b1, 32'h0, 4'b1010, 1'b0, 1'b1);
        check("sat_clear", 64'(cnt_illegal), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
